// File: rtl/rgbw_pkg.sv
// Shared definitions for the RGBW frame decoder and its neighbours:
// FSM state codes, default sync marker, channel slot indices and a
// saturating counter helper.
`timescale 1ns/1ps
package rgbw_pkg;

    typedef logic [1:0] state_t;

    localparam state_t HUNT    = 2'd0;
    localparam state_t PAYLOAD = 2'd1;
    localparam state_t CHECK   = 2'd2;

    localparam logic [7:0] SYNC_DEFAULT = 8'h55;

    // Default payload order within a frame
    localparam int CH_LINT  = 0;
    localparam int CH_COLOR = 1;
    localparam int CH_RED   = 2;
    localparam int CH_GREEN = 3;
    localparam int CH_BLUE  = 4;
    localparam int CH_WHITE = 5;
    localparam int CH_MODE  = 6;

    // Increment that sticks at 255 instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rgbw_frame_decoder_if.sv
// Byte bus from the SPI slave receiver: data plus a byte-ready level.
`timescale 1ns/1ps
interface rgbw_frame_decoder_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_rdy;

    modport master (output rx_data, output rx_rdy);
    modport slave  (input  rx_data, input  rx_rdy);
endinterface

// File: rtl/rgbw_rdy_edge.sv
// Two-flop synchroniser on a ready level with a rising-edge strobe.
// Advances only on clk edges where clk_half is low.
`timescale 1ns/1ps
module rgbw_rdy_edge (
    input  logic clk,
    input  logic reset,
    input  logic clk_half,
    input  logic rdy_in,
    output logic strobe
);

    logic rdy_s1;
    logic rdy_s2;

    // Synchronise the ready level and keep one cycle of history
    always_ff @(posedge clk) begin
        if (!clk_half) begin
            if (!reset) begin
                rdy_s1 <= 1'b0;
                rdy_s2 <= 1'b0;
            end else begin
                rdy_s1 <= rdy_in;
                rdy_s2 <= rdy_s1;
            end
        end
    end

    assign strobe = rdy_s1 & ~rdy_s2;

endmodule

// File: rtl/rgbw_frame_decoder.sv
// Frame decoder: hunts for a sync byte, gathers NUM_CH payload bytes and
// an optional checksum, then commits every channel in a single cycle.
// Reports checksum failures and inter-byte timeouts.
`timescale 1ns/1ps
module rgbw_frame_decoder
    import rgbw_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter int                NUM_CH       = 7,
    parameter logic [DATA_W-1:0] SYNC_BYTE    = DATA_W'(SYNC_DEFAULT),
    parameter bit                USE_CHECKSUM = 1'b1,
    parameter int                TIMEOUT_CYC  = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_half,
    rgbw_frame_decoder_if.slave      rx,
    output logic [NUM_CH*DATA_W-1:0] ch_out,
    output logic                     frame_valid,
    output logic                     frame_err,
    output logic [7:0]               err_cnt,
    output logic                     busy
);

    localparam int IDX_W = $clog2(NUM_CH + 1);
    localparam int TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    logic                     en;
    logic                     strobe;
    state_t                   state;
    logic [IDX_W-1:0]         idx;
    logic [DATA_W-1:0]        sum;
    logic [TMR_W-1:0]         timer;
    logic [NUM_CH*DATA_W-1:0] shadow;
    logic [NUM_CH*DATA_W-1:0] shadow_wr;
    logic                     timeout_hit;

    assign en   = ~clk_half;
    assign busy = (state != HUNT);

    rgbw_rdy_edge u_rdy_edge (
        .clk      (clk),
        .reset    (reset),
        .clk_half (clk_half),
        .rdy_in   (rx.rx_rdy),
        .strobe   (strobe)
    );

    // Timer expiry only matters when a timeout is configured
    assign timeout_hit = (TIMEOUT_CYC > 0) && (timer == TMR_LAST);

    // Shadow image with the incoming byte placed at the current slot; also
    // serves as the commit image when there is no checksum byte
    always_comb begin
        shadow_wr = shadow;
        shadow_wr[int'(idx)*DATA_W +: DATA_W] = rx.rx_data;
    end

    // Frame FSM, shadow capture, commit and error reporting
    always_ff @(posedge clk) begin
        if (en) begin
            if (!reset) begin
                state       <= HUNT;
                idx         <= '0;
                sum         <= '0;
                timer       <= '0;
                shadow      <= '0;
                ch_out      <= '0;
                frame_valid <= 1'b0;
                frame_err   <= 1'b0;
                err_cnt     <= 8'd0;
            end else begin
                frame_valid <= 1'b0;
                frame_err   <= 1'b0;
                case (state)
                    HUNT: begin
                        if (strobe && rx.rx_data == SYNC_BYTE) begin
                            idx   <= '0;
                            sum   <= '0;
                            timer <= '0;
                            state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        if (strobe) begin
                            shadow <= shadow_wr;
                            sum    <= sum + rx.rx_data;
                            idx    <= idx + 1'b1;
                            timer  <= '0;
                            if (idx == IDX_LAST) begin
                                if (USE_CHECKSUM) begin
                                    state <= CHECK;
                                end else begin
                                    ch_out      <= shadow_wr;
                                    frame_valid <= 1'b1;
                                    state       <= HUNT;
                                end
                            end
                        end else if (timeout_hit) begin
                            frame_err <= 1'b1;
                            err_cnt   <= sat_inc8(err_cnt);
                            state     <= HUNT;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    CHECK: begin
                        if (strobe) begin
                            timer <= '0;
                            if (rx.rx_data == sum) begin
                                ch_out      <= shadow;
                                frame_valid <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                                err_cnt   <= sat_inc8(err_cnt);
                            end
                            state <= HUNT;
                        end else if (timeout_hit) begin
                            frame_err <= 1'b1;
                            err_cnt   <= sat_inc8(err_cnt);
                            state     <= HUNT;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rgbw_frame_decoder.sv
// Bench for rgbw_frame_decoder: three instances (default, short timeout,
// three channels without checksum) driven with directed and random frames.
`timescale 1ns/1ps
module tb_rgbw_frame_decoder;

    logic clk      = 1'b0;
    logic clk_half = 1'b0;
    logic reset    = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) clk_half <= ~clk_half;

    rgbw_frame_decoder_if #(.DATA_W(8)) rx0 ();
    rgbw_frame_decoder_if #(.DATA_W(8)) rx1 ();
    rgbw_frame_decoder_if #(.DATA_W(8)) rx2 ();

    logic [55:0] ch0, ch1;
    logic [23:0] ch2;
    logic        fv0, fv1, fv2, fe0, fe1, fe2, bz0, bz1, bz2;
    logic [7:0]  ec0, ec1, ec2;

    rgbw_frame_decoder dut0 (
        .clk(clk), .reset(reset), .clk_half(clk_half), .rx(rx0),
        .ch_out(ch0), .frame_valid(fv0), .frame_err(fe0), .err_cnt(ec0), .busy(bz0)
    );

    rgbw_frame_decoder #(.TIMEOUT_CYC(16)) dut1 (
        .clk(clk), .reset(reset), .clk_half(clk_half), .rx(rx1),
        .ch_out(ch1), .frame_valid(fv1), .frame_err(fe1), .err_cnt(ec1), .busy(bz1)
    );

    rgbw_frame_decoder #(.NUM_CH(3), .USE_CHECKSUM(1'b0)) dut2 (
        .clk(clk), .reset(reset), .clk_half(clk_half), .rx(rx2),
        .ch_out(ch2), .frame_valid(fv2), .frame_err(fe2), .err_cnt(ec2), .busy(bz2)
    );

    // Pulse counters: count rising edges of each pulse output
    int   nv0 = 0, nv1 = 0, nv2 = 0, ne0 = 0, ne1 = 0, ne2 = 0;
    logic fv0_q = 1'b0, fv1_q = 1'b0, fv2_q = 1'b0;
    logic fe0_q = 1'b0, fe1_q = 1'b0, fe2_q = 1'b0;

    always @(negedge clk) begin
        fv0_q <= fv0; fv1_q <= fv1; fv2_q <= fv2;
        fe0_q <= fe0; fe1_q <= fe1; fe2_q <= fe2;
        if (fv0 && !fv0_q) nv0 <= nv0 + 1;
        if (fv1 && !fv1_q) nv1 <= nv1 + 1;
        if (fv2 && !fv2_q) nv2 <= nv2 + 1;
        if (fe0 && !fe0_q) ne0 <= ne0 + 1;
        if (fe1 && !fe1_q) ne1 <= ne1 + 1;
        if (fe2 && !fe2_q) ne2 <= ne2 + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic [7:0] d, input logic r);
        case (w)
            0:       begin rx0.rx_data = d; rx0.rx_rdy = r; end
            1:       begin rx1.rx_data = d; rx1.rx_rdy = r; end
            default: begin rx2.rx_data = d; rx2.rx_rdy = r; end
        endcase
    endtask

    task automatic send_byte(input int w, input logic [7:0] b, input int hold);
        @(negedge clk);
        drive(w, b, 1'b1);
        repeat (hold) @(negedge clk);
        drive(w, b, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input int w, input logic [7:0] p [7], input logic [7:0] ck);
        send_byte(w, 8'h55, 4);
        for (int i = 0; i < 7; i++) send_byte(w, p[i], 4);
        send_byte(w, ck, 4);
    endtask

    // Reference: checksum is the byte sum modulo 256
    function automatic logic [7:0] csum(input logic [7:0] p [7]);
        int s = 0;
        for (int i = 0; i < 7; i++) s += int'(p[i]);
        return 8'(s % 256);
    endfunction

    // Reference: channel 0 occupies the least significant byte
    function automatic logic [55:0] pack7(input logic [7:0] p [7]);
        logic [55:0] v = '0;
        for (int i = 0; i < 7; i++) v[i*8 +: 8] = p[i];
        return v;
    endfunction

    logic [7:0]  p [7];
    logic [7:0]  ck;
    logic [55:0] exp_ch0;
    int          exp_err0;
    int          bv, be;
    logic [7:0]  g;
    bit          good;

    initial begin
        drive(0, 8'h00, 1'b0);
        drive(1, 8'h00, 1'b0);
        drive(2, 8'h00, 1'b0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_ch0", ch0, 0);
        chk("rst_fv0", fv0, 0);
        chk("rst_fe0", fe0, 0);
        chk("rst_ec0", ec0, 0);
        chk("rst_bz0", bz0, 0);
        chk("rst_ch2", ch2, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Known-good frame
        p = '{8'h10, 8'h02, 8'hFF, 8'h80, 8'h00, 8'h40, 8'h01};
        bv = nv0; be = ne0;
        send_frame(0, p, 8'hD2);
        exp_ch0 = 56'h01_40_00_80_FF_02_10;
        exp_err0 = 0;
        chk("t1_ch", ch0, exp_ch0);
        chk("t1_valid_pulses", nv0 - bv, 1);
        chk("t1_err_pulses", ne0 - be, 0);
        chk("t1_err_cnt", ec0, 0);
        chk("t1_busy", bz0, 0);

        // Same frame, wrong checksum
        bv = nv0; be = ne0;
        send_frame(0, p, 8'h00);
        exp_err0++;
        chk("t2_ch_kept", ch0, exp_ch0);
        chk("t2_err_pulses", ne0 - be, 1);
        chk("t2_valid_pulses", nv0 - bv, 0);
        chk("t2_err_cnt", ec0, exp_err0);

        // Garbage before sync, sync value inside payload
        be = ne0; bv = nv0;
        send_byte(0, 8'h00, 4);
        send_byte(0, 8'hAA, 4);
        send_byte(0, 8'h13, 4);
        chk("t3_busy_after_garbage", bz0, 0);
        chk("t3_no_err", ne0 - be, 0);
        p = '{8'h55, 8'h11, 8'h22, 8'h55, 8'h33, 8'h44, 8'h55};
        send_frame(0, p, csum(p));
        exp_ch0 = pack7(p);
        chk("t3_ch", ch0, exp_ch0);
        chk("t3_valid_pulses", nv0 - bv, 1);
        chk("t3_err_cnt", ec0, exp_err0);

        // Random frames, mostly good, some with leading garbage
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 7; i++) p[i] = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            ck = good ? csum(p) : 8'(int'(csum(p)) + 1 + int'($urandom_range(0, 254)));
            if ($urandom_range(0, 1) == 1) begin
                g = 8'($urandom);
                if (g == 8'h55) g = 8'h56;
                send_byte(0, g, 4);
            end
            send_frame(0, p, ck);
            if (good) exp_ch0 = pack7(p);
            else      exp_err0++;
            chk("rnd_ch", ch0, exp_ch0);
            chk("rnd_err_cnt", ec0, exp_err0);
        end

        // Inter-byte timeout on the short-timeout instance
        send_byte(1, 8'h55, 4);
        send_byte(1, 8'h01, 4);
        send_byte(1, 8'h02, 4);
        repeat (16) @(negedge clk);
        chk("t4_busy_before_timeout", bz1, 1);
        chk("t4_no_early_err", ne1, 0);
        repeat (24) @(negedge clk);
        chk("t4_err_pulses", ne1, 1);
        chk("t4_err_cnt", ec1, 1);
        chk("t4_busy_after", bz1, 0);
        chk("t4_ch_kept", ch1, 0);
        for (int i = 0; i < 7; i++) p[i] = 8'($urandom);
        send_frame(1, p, csum(p));
        chk("t4_ch_after", ch1, pack7(p));
        chk("t4_valid_pulses", nv1, 1);
        chk("t4_err_cnt_after", ec1, 1);

        // Three channels, no checksum
        send_byte(2, 8'h55, 4);
        send_byte(2, 8'hAA, 4);
        send_byte(2, 8'hBB, 4);
        send_byte(2, 8'hCC, 4);
        chk("t6_ch", ch2, 24'hCCBBAA);
        chk("t6_valid_pulses", nv2, 1);
        chk("t6_busy", bz2, 0);
        chk("t6_err", ne2, 0);

        // Reset in the middle of a frame
        be = ne0;
        send_byte(0, 8'h55, 4);
        for (int i = 0; i < 4; i++) send_byte(0, 8'(8'h20 + i), 4);
        chk("t5_busy_mid", bz0, 1);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("t5_ch_cleared", ch0, 0);
        chk("t5_busy", bz0, 0);
        chk("t5_err_cnt", ec0, 0);
        chk("t5_no_err_pulse", ne0 - be, 0);
        exp_ch0 = '0;
        exp_err0 = 0;

        // A long-held ready level counts as one byte
        bv = nv0;
        p = '{8'hA1, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        send_byte(0, 8'h55, 4);
        send_byte(0, p[0], 20);
        for (int i = 1; i < 7; i++) send_byte(0, p[i], 4);
        send_byte(0, csum(p), 4);
        exp_ch0 = pack7(p);
        chk("t5_hold_ch", ch0, exp_ch0);
        chk("t5_hold_valid", nv0 - bv, 1);
        chk("t5_hold_err_cnt", ec0, 0);

        // Error counter saturation
        be = ne0;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 7; i++) p[i] = 8'($urandom);
            send_frame(0, p, 8'(int'(csum(p)) + 1));
            exp_err0 = (exp_err0 < 255) ? exp_err0 + 1 : 255;
        end
        chk("sat_err_cnt", ec0, exp_err0);
        chk("sat_err_pulses", ne0 - be, 300);
        chk("sat_ch_kept", ch0, exp_ch0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgbw_frame_decoder.md
Name: rgbw_frame_decoder

Overview:
Parametrised successor of the SPI byte dispatcher. Hunts for a sync byte, collects NUM_CH payload bytes and an optional checksum byte from the SPI receive buffer, then commits all channel registers atomically in one enabled cycle. Adds checksum validation, an inter-byte timeout, error reporting and a frame-valid pulse. Sits between the SPI slave receiver and the colour generator / PWM blocks; runs on the clk_half enable like its neighbours.

Parameters:
DATA_W, 8, width of every received byte and channel register
NUM_CH, 7, payload bytes per frame (default order: lint, colorIdx, red, green, blue, white, mode)
SYNC_BYTE, 8'h55, frame start marker
USE_CHECKSUM, 1, 1 = one trailing checksum byte required; 0 = commit straight after last payload byte
TIMEOUT_CYC, 1024, enabled cycles allowed between accepted bytes inside a frame; 0 disables the timeout

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
clk_half  in  1  clock enable; all state advances only on clk edges with clk_half == 0
rx_data  in  DATA_W  received byte; stable while rx_rdy high
rx_rdy  in  1  byte-ready level from SPI receiver
ch_out  out  NUM_CH*DATA_W  committed channels; channel i at [i*DATA_W +: DATA_W], channel 0 = first payload byte
frame_valid  out  1  one-enabled-cycle pulse when a frame commits
frame_err  out  1  one-enabled-cycle pulse on checksum mismatch or timeout
err_cnt  out  8  saturating error counter (stops at 255)
busy  out  1  high when not in HUNT

Behaviour:
- Enabled edge = posedge clk with clk_half == 0. Reset (reset == 0) is sampled only on enabled edges, same as the rest of the design.
- Reset: ch_out = 0, frame_valid = 0, frame_err = 0, err_cnt = 0, busy = 0, state = HUNT, shadow registers/index/checksum/timer = 0, both rx_rdy sync flops = 0.
- Byte strobe: rdy_s1 <= rx_rdy; rdy_s2 <= rdy_s1; strobe = rdy_s1 & ~rdy_s2. Only a rising edge of rx_rdy counts as a byte, so a level held high yields exactly one byte. rx_data is captured in the enabled cycle in which strobe is asserted.
- FSM: HUNT -> PAYLOAD -> (CHECK) -> HUNT.
  - HUNT: on strobe with rx_data == SYNC_BYTE: idx = 0, sum = 0, timer = 0, go to PAYLOAD. Any other byte is discarded silently with no error.
  - PAYLOAD: on strobe, shadow[idx] <= rx_data, sum <= sum + rx_data (mod 2^DATA_W), idx++. A byte equal to SYNC_BYTE is plain data; there is no resync. When idx == NUM_CH-1: go to CHECK if USE_CHECKSUM, else commit and go to HUNT.
  - CHECK: on strobe, if rx_data == sum, commit; otherwise error. Either way go to HUNT.
- Commit: ch_out <= shadow, with the last payload byte taken directly from rx_data when USE_CHECKSUM = 0. frame_valid = 1 for that enabled cycle. ch_out never shows a partial frame.
- Latency: ch_out/frame_valid update on the 2nd enabled edge after rx_rdy of the final byte is first sampled high.
- Error: frame_err = 1 for one enabled cycle; err_cnt++ unless it is already 255; ch_out unchanged; shadow is not cleared.
- Timeout (TIMEOUT_CYC > 0): timer counts enabled cycles in PAYLOAD/CHECK and clears on every strobe. When timer reaches TIMEOUT_CYC-1 with no strobe, raise error and go to HUNT. If a strobe and the timeout expiry occur in the same cycle, the strobe wins.
- Pulses are cleared on the next enabled edge. On non-enabled edges all outputs hold; pulse width is measured in enabled cycles.
- Reset mid-frame: frame is abandoned, ch_out clears to 0, no frame_err.
- Timer width is clog2(TIMEOUT_CYC+1). idx width is clog2(NUM_CH+1).

Decomposition:
- Package rgbw_pkg: state enum (HUNT, PAYLOAD, CHECK), default SYNC_BYTE, channel index constants (CH_LINT=0 … CH_MODE=6).
- One sub-module: rgbw_rdy_edge (2-flop sync + rising-edge strobe, gated by clk_half), reusable by other SPI consumers.

Test Plan:
1. Default params; send 55 10 02 FF 80 00 40 01 D2 (checksum = sum mod 256 = D2) -> ch_out = {01,40,00,80,FF,02,10} (ch6..ch0); frame_valid pulses once; err_cnt = 0.
2. Same frame with checksum 00 -> frame_err pulses once; err_cnt = 1; ch_out keeps its previous value.
3. Leading garbage 00 AA 13, then a valid frame -> garbage ignored with no error; frame commits. Payload containing 55 is accepted as data.
4. TIMEOUT_CYC = 16; send 55 01 02 then idle 16 enabled cycles -> frame_err and err_cnt++; busy falls; the following valid frame commits normally.
5. Assert reset after 4 payload bytes -> ch_out = 0, busy = 0, no frame_err; hold rx_rdy high 10 cycles -> counted as one byte only.
6. USE_CHECKSUM = 0, NUM_CH = 3; 55 AA BB CC -> ch_out = CCBBAA. Force 300 bad frames (default params) -> err_cnt saturates at 255.
